cpu_sequencer: RTL and testbench



---
 rtl/cpu_seq_pkg.sv | 49 ++++
 rtl/cpu_seq_mem_watchdog.sv | 33 +++
 rtl/cpu_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, decoder
// instruction classes, register-file write-source selects and the strobe bundle.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_BASE_WB   = 3'd6,
    ST_FAULT     = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    CLS_DP  = 2'b00,
    CLS_LS  = 2'b01,
    CLS_BR  = 2'b10,
    CLS_UND = 2'b11
  } instr_class_t;

  typedef enum logic [1:0] {
    WSEL_ALU_RD  = 2'b00,
    WSEL_MEM_RD  = 2'b01,
    WSEL_PC4_LR  = 2'b10,
    WSEL_ADDR_RN = 2'b11
  } rf_wsel_t;

  localparam int MEM_TIMEOUT_DEFAULT = 16;
  // Wide enough for the largest legal timeout (255).
  localparam int WDOG_W = 8;

  typedef struct packed {
    logic     ir_write;
    logic     rf_read_en;
    logic     alu_en;
    logic     cpsr_write;
    logic     pc_write;
    logic     branch_take;
    logic     dmem_req;
    logic     dmem_we;
    logic     rf_write_en;
    rf_wsel_t rf_wsel;
    logic     retire;
    logic     fault;
  } ctrl_t;

endpackage

// File: rtl/cpu_seq_mem_watchdog.sv
// Data-memory wait watchdog: counts cycles spent in MEMORY and flags the cycle
// on which MEM_TIMEOUT (1..255) wait cycles have been used up.
module cpu_seq_mem_watchdog
  import cpu_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic nreset,
  input  logic active,
  output logic expired
);

  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(MEM_TIMEOUT - 1);

  logic [WDOG_W-1:0] wait_cnt;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wait_cnt <= '0;
    end else if (!active) begin
      wait_cnt <= '0;
    end else if (wait_cnt != LIMIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Asserted during the MEM_TIMEOUT-th MEMORY cycle; an ack in that cycle wins.
  assign expired = active && (wait_cnt == LIMIT);

endmodule

// File: rtl/cpu_sequencer.sv
// Multicycle sequencer for the ARM datapath: FETCH/DECODE/EXECUTE/MEMORY/
// WRITEBACK control strobes. Define CPU_SEQ_PERF_CNT_EN to build the counters.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             run,
  input  logic [1:0]       instr_class,
  input  logic             is_load,
  input  logic             s_bit,
  input  logic             link_bit,
  input  logic             base_wb,
  input  logic             cond_pass,
  input  logic             dmem_ack,
  output logic             ir_write,
  output logic             rf_read_en,
  output logic             alu_en,
  output logic             cpsr_write,
  output logic             pc_write,
  output logic             branch_take,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_write_en,
  output logic [1:0]       rf_wsel,
  output logic             retire,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t       state_q, state_d, after_retire;
  instr_class_t cls;
  ctrl_t        ctl;
  logic         mem_expired;
  logic         load_base_wb;

  assign cls          = instr_class_t'(instr_class);
  assign after_retire = run ? ST_FETCH : ST_IDLE;
  assign load_base_wb = (cls == CLS_LS) && is_load && base_wb;

  cpu_seq_mem_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .nreset (nreset),
    .active (state_q == ST_MEMORY),
    .expired(mem_expired)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every combinational block assigns a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (run) state_d = ST_FETCH;
      ST_FETCH:     state_d = ST_DECODE;
      ST_DECODE: begin
        if (cls == CLS_UND)  state_d = ST_FAULT;
        else if (!cond_pass) state_d = after_retire;
        else                 state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        case (cls)
          CLS_DP:  state_d = ST_WRITEBACK;
          CLS_LS:  state_d = ST_MEMORY;
          CLS_BR:  state_d = link_bit ? ST_WRITEBACK : after_retire;
          default: state_d = ST_FAULT;
        endcase
      end
      ST_MEMORY: begin
        if (dmem_ack) begin
          if (is_load)      state_d = ST_WRITEBACK;
          else if (base_wb) state_d = ST_BASE_WB;
          else              state_d = after_retire;
        end else if (mem_expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_WRITEBACK: state_d = load_base_wb ? ST_BASE_WB : after_retire;
      ST_BASE_WB:   state_d = after_retire;
      ST_FAULT:     state_d = ST_FAULT;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ctl = '0;
    case (state_q)
      ST_FETCH: ctl.ir_write = 1'b1;
      ST_DECODE: begin
        ctl.rf_read_en = 1'b1;
        if (cls != CLS_UND && !cond_pass) begin
          ctl.pc_write = 1'b1;
          ctl.retire   = 1'b1;
        end
      end
      ST_EXECUTE: begin
        ctl.alu_en = 1'b1;
        if (cls == CLS_DP) ctl.cpsr_write = s_bit;
        if (cls == CLS_BR) begin
          ctl.branch_take = 1'b1;
          ctl.pc_write    = 1'b1;
          ctl.retire      = !link_bit;
        end
      end
      ST_MEMORY: begin
        ctl.dmem_req = 1'b1;
        ctl.dmem_we  = !is_load;
        if (dmem_ack && !is_load && !base_wb) begin
          ctl.pc_write = 1'b1;
          ctl.retire   = 1'b1;
        end
      end
      ST_WRITEBACK: begin
        ctl.rf_write_en = 1'b1;
        case (cls)
          CLS_LS:  ctl.rf_wsel = WSEL_MEM_RD;
          CLS_BR:  ctl.rf_wsel = WSEL_PC4_LR;
          default: ctl.rf_wsel = WSEL_ALU_RD;
        endcase
        // BL already loaded the branch target into PC during EXECUTE.
        ctl.pc_write = (cls != CLS_BR);
        ctl.retire   = !load_base_wb;
      end
      ST_BASE_WB: begin
        ctl.rf_write_en = 1'b1;
        ctl.rf_wsel     = WSEL_ADDR_RN;
        ctl.pc_write    = 1'b1;
        ctl.retire      = 1'b1;
      end
      ST_FAULT: ctl.fault = 1'b1;
      default:  ctl = '0;
    endcase
  end

  assign ir_write    = ctl.ir_write;
  assign rf_read_en  = ctl.rf_read_en;
  assign alu_en      = ctl.alu_en;
  assign cpsr_write  = ctl.cpsr_write;
  assign pc_write    = ctl.pc_write;
  assign branch_take = ctl.branch_take;
  assign dmem_req    = ctl.dmem_req;
  assign dmem_we     = ctl.dmem_we;
  assign rf_write_en = ctl.rf_write_en;
  assign rf_wsel     = ctl.rf_wsel;
  assign retire      = ctl.retire;
  assign fault       = ctl.fault;
  assign state       = state_q;

`ifdef CPU_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] instr_q, stall_q;

  // Both counters saturate at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      instr_q <= '0;
      stall_q <= '0;
    end else begin
      if (ctl.retire && instr_q != '1) instr_q <= instr_q + 1'b1;
      if (state_q == ST_MEMORY && !dmem_ack && stall_q != '1) stall_q <= stall_q + 1'b1;
    end
  end

  assign instr_cnt = instr_q;
  assign stall_cnt = stall_q;
`else
  assign instr_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomised bench for cpu_sequencer: an instruction-level model lists the
// expected per-cycle strobes for each instruction and every cycle is compared.
module tb_cpu_sequencer;

  localparam int T     = 4;
  localparam int CNT_W = 16;
`ifdef CPU_SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_BWB = 3'd6, S_FAULT = 3'd7;

  typedef struct packed {
    logic [2:0] st;
    logic       flt, ret;
    logic [1:0] wsel;
    logic       rfw, we, req, bt, pcw, cpsr, alu, rfr, irw;
  } obs_t;

  logic clk = 1'b0, nreset = 1'b0, run = 1'b0;
  logic [1:0] instr_class = 2'b00;
  logic is_load = 1'b0, s_bit = 1'b0, link_bit = 1'b0, base_wb = 1'b0;
  logic cond_pass = 1'b0, dmem_ack = 1'b0;
  logic ir_write, rf_read_en, alu_en, cpsr_write, pc_write, branch_take;
  logic dmem_req, dmem_we, rf_write_en, retire, fault;
  logic [1:0] rf_wsel;
  logic [2:0] state;
  logic [CNT_W-1:0] instr_cnt, stall_cnt;
  logic [1:0] sat_instr_cnt, sat_stall_cnt;
  obs_t got;

  always #5 clk = ~clk;

  cpu_sequencer #(.MEM_TIMEOUT(T), .CNT_W(CNT_W)) dut (
    .clk(clk), .nreset(nreset), .run(run), .instr_class(instr_class), .is_load(is_load),
    .s_bit(s_bit), .link_bit(link_bit), .base_wb(base_wb), .cond_pass(cond_pass),
    .dmem_ack(dmem_ack), .ir_write(ir_write), .rf_read_en(rf_read_en), .alu_en(alu_en),
    .cpsr_write(cpsr_write), .pc_write(pc_write), .branch_take(branch_take),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_write_en(rf_write_en), .rf_wsel(rf_wsel),
    .retire(retire), .fault(fault), .state(state), .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
  );

  // Narrow-counter copy sharing all inputs, used only to observe saturation.
  logic s_irw, s_rfr, s_alu, s_cpsr, s_pcw, s_bt, s_req, s_we, s_rfw, s_ret, s_flt;
  logic [1:0] s_wsel;
  logic [2:0] s_state;
  cpu_sequencer #(.MEM_TIMEOUT(T), .CNT_W(2)) dut_sat (
    .clk(clk), .nreset(nreset), .run(run), .instr_class(instr_class), .is_load(is_load),
    .s_bit(s_bit), .link_bit(link_bit), .base_wb(base_wb), .cond_pass(cond_pass),
    .dmem_ack(dmem_ack), .ir_write(s_irw), .rf_read_en(s_rfr), .alu_en(s_alu),
    .cpsr_write(s_cpsr), .pc_write(s_pcw), .branch_take(s_bt), .dmem_req(s_req),
    .dmem_we(s_we), .rf_write_en(s_rfw), .rf_wsel(s_wsel), .retire(s_ret), .fault(s_flt),
    .state(s_state), .instr_cnt(sat_instr_cnt), .stall_cnt(sat_stall_cnt)
  );

  assign got = {state, fault, retire, rf_wsel, rf_write_en, dmem_we, dmem_req,
                branch_take, pc_write, cpsr_write, alu_en, rf_read_en, ir_write};

  int   n_vec = 0, n_err = 0;
  int   m_instr = 0, m_stall = 0;
  obs_t exp_q[$];
  bit   ends_in_fault;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic obs_t mk(input logic [2:0] st);
    obs_t o;
    o    = '0;
    o.st = st;
    return o;
  endfunction

  function automatic obs_t base_wb_cycle();
    obs_t o;
    o      = mk(S_BWB);
    o.rfw  = 1'b1;
    o.wsel = 2'b11;
    o.pcw  = 1'b1;
    o.ret  = 1'b1;
    return o;
  endfunction

  // Expected strobes, cycle by cycle from FETCH, for one instruction whose
  // memory ack (if any) comes after w wait cycles; w >= T means no ack.
  function automatic void build(input int cls, input bit ld, input bit s, input bit lnk,
                                input bit bwb, input bit cond, input int w);
    obs_t o;
    exp_q.delete();
    ends_in_fault = 1'b0;
    o = mk(S_FETCH); o.irw = 1'b1; exp_q.push_back(o);
    o = mk(S_DECODE); o.rfr = 1'b1;
    if (cls == 3) begin exp_q.push_back(o); ends_in_fault = 1'b1; return; end
    if (!cond) begin o.pcw = 1'b1; o.ret = 1'b1; exp_q.push_back(o); return; end
    exp_q.push_back(o);
    o = mk(S_EXEC); o.alu = 1'b1;
    if (cls == 0) o.cpsr = s;
    if (cls == 2) begin o.bt = 1'b1; o.pcw = 1'b1; o.ret = !lnk; end
    exp_q.push_back(o);
    if (cls == 2 && !lnk) return;
    if (cls == 1) begin
      for (int i = 0; i < w && i < T; i++) begin
        o = mk(S_MEM); o.req = 1'b1; o.we = !ld; exp_q.push_back(o);
      end
      if (w >= T) begin ends_in_fault = 1'b1; return; end
      o = mk(S_MEM); o.req = 1'b1; o.we = !ld;
      if (!ld && !bwb) begin o.pcw = 1'b1; o.ret = 1'b1; exp_q.push_back(o); return; end
      exp_q.push_back(o);
      if (!ld) begin exp_q.push_back(base_wb_cycle()); return; end
    end
    o = mk(S_WB); o.rfw = 1'b1;
    o.wsel = (cls == 1) ? 2'b01 : (cls == 2) ? 2'b10 : 2'b00;
    o.pcw  = (cls != 2);
    o.ret  = !(cls == 1 && bwb);
    exp_q.push_back(o);
    if (cls == 1 && bwb) exp_q.push_back(base_wb_cycle());
  endfunction

  task automatic check_counters(input string tag);
    int sat_i, sat_s;
    sat_i = (m_instr > 3) ? 3 : m_instr;
    sat_s = (m_stall > 3) ? 3 : m_stall;
    check({tag, "_icnt"}, 32'(instr_cnt), PERF ? 32'(m_instr) : 32'd0);
    check({tag, "_scnt"}, 32'(stall_cnt), PERF ? 32'(m_stall) : 32'd0);
    check({tag, "_icnt_sat"}, 32'(sat_instr_cnt), PERF ? 32'(sat_i) : 32'd0);
    check({tag, "_scnt_sat"}, 32'(sat_stall_cnt), PERF ? 32'(sat_s) : 32'd0);
  endtask

  // n cycles parked with run=0, then one IDLE cycle with run=1.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      run = 1'b0; dmem_ack = 1'($urandom);
      #1 check("idle", 32'(got), 32'(mk(S_IDLE)));
      check_counters("idle");
    end
    @(negedge clk);
    run = 1'b1; dmem_ack = 1'($urandom);
    #1 check("idle_go", 32'(got), 32'(mk(S_IDLE)));
  endtask

  // Async reset pulse in the low clock phase; outputs must drop before any edge.
  task automatic do_reset();
    #2 nreset = 1'b0;
    #1 check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_out", 32'(got), 32'(mk(S_IDLE)));
    m_instr = 0;
    m_stall = 0;
    check_counters("rst");
    run = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic run_instr(input string tag, input int cls, input bit ld, input bit s,
                           input bit lnk, input bit bwb, input bit cond, input int w,
                           input bit run_ret, input int abort_at);
    bit goes_mem, last;
    obs_t fo;
    goes_mem = (cls == 1) && cond;
    build(cls, ld, s, lnk, bwb, cond, w);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == 0) begin
        instr_class = 2'(cls); is_load = ld; s_bit = s;
        link_bit = lnk; base_wb = bwb; cond_pass = cond;
      end
      last = (i == exp_q.size() - 1) && !ends_in_fault;
      run  = last ? run_ret : 1'($urandom);
      if (goes_mem && i >= 3 && i < 3 + w) dmem_ack = 1'b0;
      else if (goes_mem && i == 3 + w)     dmem_ack = 1'b1;
      else                                 dmem_ack = 1'($urandom);
      #1 check($sformatf("%s_c%0d", tag, i), 32'(got), 32'(exp_q[i]));
      if (i == 0) check_counters(tag);
      if (i == abort_at) begin
        do_reset();
        idle_cycles(0);
        return;
      end
    end
    if (goes_mem) m_stall += (w >= T) ? T : w;
    if (!ends_in_fault) m_instr++;
    if (ends_in_fault) begin
      fo = mk(S_FAULT);
      fo.flt = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        run = 1'($urandom); dmem_ack = 1'($urandom);
        #1 check({tag, "_fault"}, 32'(got), 32'(fo));
        check_counters({tag, "_fault"});
      end
      do_reset();
      idle_cycles(0);
    end else if (!run_ret) begin
      idle_cycles($urandom_range(0, 2));
    end
  endtask

  initial begin
    #1 check("reset_out", 32'(got), 32'(mk(S_IDLE)));
    check_counters("reset");
    @(negedge clk);
    nreset = 1'b1;
    idle_cycles(0);

    run_instr("dp_s",     0, 0, 1, 0, 0, 1, 0,     1, -1);
    run_instr("bl",       2, 0, 0, 1, 0, 1, 0,     1, -1);
    run_instr("ldr_wb",   1, 1, 0, 0, 1, 1, 3,     1, -1);
    run_instr("str_edge", 1, 0, 0, 0, 0, 1, T - 1, 1, -1);
    run_instr("cond_f",   0, 0, 1, 1, 1, 0, 0,     1, -1);
    run_instr("b",        2, 0, 0, 0, 0, 1, 0,     1, -1);
    run_instr("str_wb",   1, 0, 0, 0, 1, 1, 0,     0, -1);
    run_instr("str_to",   1, 0, 0, 0, 0, 1, T,     1, -1);
    run_instr("undef",    3, 0, 0, 0, 0, 1, 0,     1, -1);
    run_instr("ldr_rst",  1, 1, 0, 0, 0, 1, 3,     1, 4);

    for (int n = 0; n < 300; n++) begin
      int cls, w, ab;
      cls = ($urandom_range(0, 19) == 0) ? 3 : $urandom_range(0, 2);
      w   = ($urandom_range(0, 9) == 0) ? T : $urandom_range(0, T - 1);
      ab  = ($urandom_range(0, 24) == 0) ? $urandom_range(0, 5) : -1;
      run_instr($sformatf("rnd%0d", n), cls, 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), ($urandom_range(0, 4) != 0), w,
                ($urandom_range(0, 3) != 0), ab);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "bench timeout");
  end

endmodule
